alu_op_sequencer: RTL and testbench

- Sequences the team's 8-bit ALU. Accepts byte-wide commands over a valid/ready port: load A, load B, execute, clear.
- On execute, issues one request to the ALU, waits for its ack under a timeout, captures result and flags, and presents them on a valid/ready result port.
- Sits between the tt_alu top-level I/O mapping (ui_in/uio_in command bytes) and the ALU datapath core.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_timer.sv | 39 +++
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Contents: command kind codes, FSM state type, ALU opcode codes and the
// bit positions of the {V,C,N,Z} flag nibble returned by the ALU.
package alu_seq_pkg;

    // Command kinds carried on cmd_kind
    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_EXEC   = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ALU opcodes carried in cmd_data[2:0] of an EXEC command
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Bit indices inside the flag nibble {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Bit of an EXEC command's data byte that selects chain mode
    localparam int EXEC_CHAIN_BIT = 3;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_timer.sv
// Response timer for the ALU sequencer.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset (count -> 0)
//   i_clr  restart the count at zero
//   i_en   advance the count by one
//   o_tc   count has reached TIMEOUT-1
// The caller stops enabling the counter once o_tc is seen, so with a width of
// $clog2(TIMEOUT+1) bits the count can never wrap.
module alu_seq_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    logic [TW-1:0] r_count;

    // Cycle counter: clear has priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule : alu_seq_timer

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer.
// Accepts LOAD_A / LOAD_B / EXEC / CLEAR commands, issues one request per
// EXEC to the ALU, waits for alu_ack under a timeout and presents the
// captured result on a valid/ready result port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_kind/cmd_data   command port
//   alu_req/alu_op/alu_a/alu_b       request to the ALU (operands always driven)
//   alu_ack/alu_result/alu_flags     ALU response
//   res_valid/res_ready/res_data/res_flags/res_err   result port
//   busy                             sequencer not idle
// All handshake outputs are flops updated together with the state, so there
// is no combinational path from any input to any output.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_kind,
    input  logic [W-1:0] cmd_data,
    output logic         alu_req,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_ack,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [3:0]   res_flags,
    output logic         res_err,
    output logic         busy
);

    state_t       r_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_last;
    logic [2:0]   r_op;
    logic [W-1:0] r_res_data;
    logic [3:0]   r_res_flags;
    logic         r_res_err;
    logic         r_cmd_ready;
    logic         r_alu_req;
    logic         r_res_valid;
    logic         r_busy;

    logic w_exec_fire;
    logic w_timer_en;
    logic w_tc;

    // cmd_ready is only high in IDLE, so this is exactly "EXEC accepted"
    assign w_exec_fire = cmd_valid & r_cmd_ready & (cmd_kind == CMD_EXEC);
    // Count only while waiting; freezing at terminal count keeps it from wrapping
    assign w_timer_en  = (r_state == S_REQ) & ~alu_ack & ~w_tc;

    alu_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_exec_fire),
        .i_en  (w_timer_en),
        .o_tc  (w_tc)
    );

    // Sequencer FSM with operand/result registers and registered handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= '0;
            r_op        <= 3'd0;
            r_res_data  <= '0;
            r_res_flags <= 4'd0;
            r_res_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_alu_req   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_kind)
                            CMD_LOAD_A: r_a <= cmd_data;
                            CMD_LOAD_B: r_b <= cmd_data;
                            CMD_EXEC: begin
                                r_op <= cmd_data[2:0];
                                // Chain mode feeds the last good result back as A
                                if (cmd_data[EXEC_CHAIN_BIT]) begin
                                    r_a <= r_last;
                                end
                                r_state     <= S_REQ;
                                r_cmd_ready <= 1'b0;
                                r_alu_req   <= 1'b1;
                                r_busy      <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                r_a    <= '0;
                                r_b    <= '0;
                                r_last <= '0;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_REQ: begin
                    // Ack is checked first so it wins over a coincident timeout
                    if (alu_ack) begin
                        r_res_data  <= alu_result;
                        r_res_flags <= alu_flags;
                        r_res_err   <= 1'b0;
                        r_last      <= alu_result;
                        r_state     <= S_RESP;
                        r_alu_req   <= 1'b0;
                        r_res_valid <= 1'b1;
                    end else if (w_tc) begin
                        r_res_data  <= '0;
                        r_res_flags <= 4'd0;
                        r_res_err   <= 1'b1;
                        r_state     <= S_RESP;
                        r_alu_req   <= 1'b0;
                        r_res_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_alu_req   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_req   = r_alu_req;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign res_err   = r_res_err;
    assign busy      = r_busy;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a vector table for the directed
// scenarios, a hand-written reset-during-request sequence, and random
// commands checked against a command-level reference model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int W       = 8;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_kind;
    logic [W-1:0] cmd_data;
    logic         alu_req;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_ack;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [3:0]   res_flags;
    logic         res_err;
    logic         busy;

    alu_op_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_data   (cmd_data),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ack    (alu_ack),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flags  (res_flags),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural registers of the sequencer
    logic [7:0] m_a, m_b, m_last, m_res;
    logic [2:0] m_op;
    logic [3:0] m_flg;
    logic       m_err;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        int         k;     // REQ cycle index at which the ALU acks (NO_ACK = never)
        logic [7:0] res;
        logic [3:0] flg;
        int         hold;  // cycles of res_ready=0 while in RESP
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU used to generate plausible result/flag pairs
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic       v;
        v = 1'b0;
        case (op)
            OP_ADD:  begin t = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (t[7] != a[7]); end
            OP_SUB:  begin t = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (t[7] != a[7]); end
            OP_AND:  t = {1'b0, a & b};
            OP_OR:   t = {1'b0, a | b};
            OP_XOR:  t = {1'b0, a ^ b};
            OP_SHL:  t = {a, 1'b0};
            OP_SHR:  t = {a[0], 1'b0, a[7:1]};
            default: t = {1'b0, a};
        endcase
        return {v, t[8], t[7], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    // Apply one command, follow it to completion and check everything seen
    task automatic run_cmd(input logic [1:0] kind, input logic [7:0] data, input int k,
                           input logic [7:0] res_in, input logic [3:0] flg_in,
                           input int hold, input bit use_ref);
        int         lat;
        bit         ok;
        logic [7:0] res;
        logic [3:0] flg;
        logic [11:0] rf;
        chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (kind)
            CMD_LOAD_A: m_a = data;
            CMD_LOAD_B: m_b = data;
            CMD_CLEAR:  begin m_a = 8'd0; m_b = 8'd0; m_last = 8'd0; end
            default: begin
                m_op = data[2:0];
                if (data[3]) m_a = m_last;
            end
        endcase
        if (kind != CMD_EXEC) begin
            chk("load_alu_a", 32'(alu_a), 32'(m_a));
            chk("load_alu_b", 32'(alu_b), 32'(m_b));
            chk("load_busy", 32'(busy), 32'd0);
            chk("load_cmd_ready", 32'(cmd_ready), 32'd1);
            return;
        end
        res = res_in;
        flg = flg_in;
        if (use_ref) begin
            rf  = alu_ref(m_op, m_a, m_b);
            res = rf[7:0];
            flg = rf[11:8];
        end
        ok  = (k >= 0) && (k <= TIMEOUT - 1);
        lat = 1;
        while (res_valid !== 1'b1) begin
            if (lat > TIMEOUT + 3) begin
                chk("res_valid_timeout_bound", 32'(lat), 32'(TIMEOUT + 1));
                break;
            end
            chk("req_alu_req", 32'(alu_req), 32'd1);
            chk("req_operands", {21'd0, alu_op, alu_a, alu_b}, {21'd0, m_op, m_a, m_b});
            alu_ack    = (lat - 1 == k);
            alu_result = (lat - 1 == k) ? res : 8'($urandom);
            alu_flags  = (lat - 1 == k) ? flg : 4'($urandom);
            @(posedge clk); #1;
            alu_ack = 1'b0;
            lat++;
        end
        chk("exec_latency", 32'(lat), ok ? 32'(k + 2) : 32'(TIMEOUT + 1));
        if (ok) begin
            m_res = res; m_flg = flg; m_err = 1'b0; m_last = res;
        end else begin
            m_res = 8'd0; m_flg = 4'd0; m_err = 1'b1;
        end
        chk("res_data", 32'(res_data), 32'(m_res));
        chk("res_flags_err", {27'd0, res_flags, res_err}, {27'd0, m_flg, m_err});
        chk("resp_alu_req", 32'(alu_req), 32'd0);
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        // Backpressure: commands and stray acks must be ignored in RESP
        for (int i = 0; i < hold; i++) begin
            cmd_valid  = 1'b1;
            cmd_kind   = CMD_LOAD_A;
            cmd_data   = ~m_a;
            alu_ack    = 1'b1;
            alu_result = ~m_res;
            alu_flags  = ~m_flg;
            @(posedge clk); #1;
            chk("hold_state", {28'd0, res_valid, cmd_ready, busy, res_err},
                {28'd0, 1'b1, 1'b0, 1'b1, m_err});
            chk("hold_res", {20'd0, res_data, res_flags}, {20'd0, m_res, m_flg});
        end
        cmd_valid = 1'b0;
        alu_ack   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("after_hs_flags", {29'd0, res_valid, cmd_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
        chk("after_hs_res", {19'd0, res_data, res_flags, res_err}, {19'd0, m_res, m_flg, m_err});
        chk("after_hs_alu_a", 32'(alu_a), 32'(m_a));
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{CMD_LOAD_A, 8'h12, 0, 8'h00, 4'h0, 0};
        tbl[1]  = '{CMD_LOAD_B, 8'h34, 0, 8'h00, 4'h0, 0};
        tbl[2]  = '{CMD_EXEC,   8'h00, 2, 8'h46, 4'h0, 10};      // basic op + backpressure
        tbl[3]  = '{CMD_LOAD_B, 8'h01, 0, 8'h00, 4'h0, 0};
        tbl[4]  = '{CMD_EXEC,   8'h09, 1, 8'h45, 4'h0, 0};       // chain, SUB
        tbl[5]  = '{CMD_EXEC,   8'h02, NO_ACK, 8'h00, 4'h0, 2};  // timeout
        tbl[6]  = '{CMD_EXEC,   8'h0F, 0, 8'h77, 4'h2, 0};       // chain after timeout
        tbl[7]  = '{CMD_CLEAR,  8'hA5, 0, 8'h00, 4'h0, 0};
        tbl[8]  = '{CMD_EXEC,   8'h0C, 3, 8'hAB, 4'h8, 1};       // chain after clear
        tbl[9]  = '{CMD_EXEC,   8'h03, TIMEOUT - 1, 8'h5A, 4'h5, 0}; // ack on last cycle wins
        tbl[10] = '{CMD_EXEC,   8'h04, TIMEOUT, 8'h5B, 4'h1, 0};     // ack one cycle too late

        rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_data = 8'd0;
        alu_ack = 1'b0; alu_result = 8'd0; alu_flags = 4'd0; res_ready = 1'b0;
        m_a = 8'd0; m_b = 8'd0; m_last = 8'd0; m_res = 8'd0; m_op = 3'd0; m_flg = 4'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_flags", {28'd0, cmd_ready, alu_req, res_valid, busy}, {28'd0, 4'b1000});
        chk("reset_res", {19'd0, res_data, res_flags, res_err}, 32'd0);
        chk("reset_regs", {21'd0, alu_op, alu_a, alu_b}, 32'd0);

        for (int i = 0; i < 11; i++)
            run_cmd(tbl[i].kind, tbl[i].data, tbl[i].k, tbl[i].res, tbl[i].flg, tbl[i].hold, 1'b0);

        // Reset during REQ aborts the request and wipes A, B and last
        run_cmd(CMD_LOAD_A, 8'h33, 0, 8'h00, 4'h0, 0, 1'b0);
        run_cmd(CMD_LOAD_B, 8'h44, 0, 8'h00, 4'h0, 0, 1'b0);
        cmd_valid = 1'b1; cmd_kind = CMD_EXEC; cmd_data = 8'h01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            chk("midreq_alu_req", 32'(alu_req), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_a = 8'd0; m_b = 8'd0; m_last = 8'd0; m_op = 3'd0; m_res = 8'd0; m_flg = 4'd0; m_err = 1'b0;
        chk("midrst_flags", {28'd0, cmd_ready, alu_req, res_valid, busy}, {28'd0, 4'b1000});
        chk("midrst_regs", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
        alu_ack = 1'b1; alu_result = 8'h99; alu_flags = 4'hF;
        @(posedge clk); #1;
        alu_ack = 1'b0;
        chk("late_ack_ignored", {29'd0, res_valid, busy, cmd_ready}, {29'd0, 3'b001});
        chk("late_ack_res", {19'd0, res_data, res_flags, res_err}, 32'd0);
        run_cmd(CMD_EXEC, 8'h0F, 1, 8'h00, 4'h0, 0, 1'b1);  // chain: last must be 0

        // Random commands against the reference model
        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, TIMEOUT + 2),
                    8'h00, 4'h0, $urandom_range(0, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_op_sequencer
